// File: rtl/nlfsr_bit_packer_if.sv
// Word stream from the bit packer toward the TRNG read-out logic.
interface nlfsr_bit_packer_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] word_o;
    logic              word_valid;
    logic              word_ready;

    modport master (output word_o, output word_valid, input word_ready);
    modport slave  (input word_o, input word_valid, output word_ready);
endinterface

// File: rtl/nlfsr_bit_packer.sv
// Samples NLFSR2 b0 on a strobe, drops a warm-up prefix and packs bits LSB-first into a word FIFO.
// Optional repetition-count health test: define NLFSR_PACK_RCT_EN.
//
// state   | meaning
// WARMUP  | counting strobed bits to discard, nothing stored
// COLLECT | packing strobed bits into words, pushing full words
// FAIL    | health alarm raised, no further words pushed (NLFSR_PACK_RCT_EN only)
module nlfsr_bit_packer #(
    parameter int WORD_W       = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int DISCARD_BITS = 64,
    parameter int RCT_CUTOFF   = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             bit_i,
    input  logic                             bit_valid,
    input  logic                             flush,
    nlfsr_bit_packer_if.master               word_if,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fill_level,
    output logic                             overflow,
    output logic                             health_fail
);
    localparam int BW = $clog2(WORD_W);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int DW = (DISCARD_BITS > 1) ? $clog2(DISCARD_BITS) : 1;

    localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_W - 1);
    localparam logic [DW-1:0] DISC_LAST = DW'((DISCARD_BITS > 0) ? DISCARD_BITS - 1 : 0);
    localparam logic [CW-1:0] DEPTH     = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {WARMUP, COLLECT, FAIL} state_t;
    localparam state_t START = (DISCARD_BITS == 0) ? COLLECT : WARMUP;

    state_t            state, state_next;
    logic [DW-1:0]     disc_cnt, disc_cnt_next;
    logic [BW-1:0]     bit_cnt, bit_cnt_next;
    logic [WORD_W-1:0] shreg, shreg_next;
    logic              push, pop, full, push_ok, fail_trip;

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count;

`ifdef NLFSR_PACK_RCT_EN
    localparam int RW = $clog2(RCT_CUTOFF + 1);
    localparam logic [RW-1:0] CUTOFF = RW'(RCT_CUTOFF);
    logic [RW-1:0] run_cnt, run_next;
    logic          prev_bit, prev_next;
    logic          health_q;
`endif

    always_comb begin
        state_next    = state;
        disc_cnt_next = disc_cnt;
        bit_cnt_next  = bit_cnt;
        shreg_next    = shreg;
        push          = 1'b0;
        fail_trip     = 1'b0;
`ifdef NLFSR_PACK_RCT_EN
        run_next      = run_cnt;
        prev_next     = prev_bit;
`endif
        case (state)
            WARMUP: if (bit_valid) begin
                if (disc_cnt == DISC_LAST) begin
                    state_next    = COLLECT;
                    disc_cnt_next = '0;
                end else begin
                    disc_cnt_next = disc_cnt + 1'b1;
                end
            end
            COLLECT: if (bit_valid) begin
                // The completed word includes the bit strobed this cycle.
                shreg_next[bit_cnt] = bit_i;
                bit_cnt_next        = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
                push                = (bit_cnt == BIT_LAST);
`ifdef NLFSR_PACK_RCT_EN
                run_next  = (run_cnt != '0 && bit_i == prev_bit) ? run_cnt + 1'b1 : RW'(1);
                prev_next = bit_i;
                if (run_next == CUTOFF) begin
                    state_next = FAIL;
                    push       = 1'b0;
                    fail_trip  = 1'b1;
                end
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state    <= START;
            disc_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
`ifdef NLFSR_PACK_RCT_EN
            run_cnt  <= '0;
            prev_bit <= 1'b0;
            health_q <= 1'b0;
`endif
        end else begin
            state    <= state_next;
            disc_cnt <= disc_cnt_next;
            bit_cnt  <= bit_cnt_next;
            shreg    <= shreg_next;
`ifdef NLFSR_PACK_RCT_EN
            run_cnt  <= run_next;
            prev_bit <= prev_next;
            if (fail_trip) health_q <= 1'b1;
`endif
        end
    end

    // A push into a full FIFO survives only when the head leaves in the same cycle.
    assign full    = (count == DEPTH);
    assign pop     = word_if.word_valid && word_if.word_ready;
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && full && !pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && push_ok) mem[wr_ptr] <= shreg_next;
    end

    assign word_if.word_valid = (count != '0);
    assign word_if.word_o     = word_if.word_valid ? mem[rd_ptr] : '0;
    assign fill_level         = count;

`ifdef NLFSR_PACK_RCT_EN
    assign health_fail = health_q;
`else
    assign health_fail = 1'b0;
`endif
endmodule

// File: tb/tb_nlfsr_bit_packer.sv
// Directed bench for nlfsr_bit_packer with default parameters (32-bit words, depth 4, 64 warm-up bits).
module tb_nlfsr_bit_packer;
    logic       clk = 1'b0;
    logic       rst, bit_i, bit_valid, flush;
    logic [2:0] fill_level;
    logic       overflow, health_fail;
    int         checks = 0;
    int         failures = 0;

    nlfsr_bit_packer_if #(.WORD_W(32)) wif ();

    nlfsr_bit_packer dut (
        .clk         (clk),
        .rst         (rst),
        .bit_i       (bit_i),
        .bit_valid   (bit_valid),
        .flush       (flush),
        .word_if     (wif),
        .fill_level  (fill_level),
        .overflow    (overflow),
        .health_fail (health_fail)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] stim;
        logic [31:0] exp_head;
        logic [2:0]  exp_fill;
    } vec_t;

    vec_t        vecs [3];
    logic [31:0] words [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic warmup(input int n);
        for (int i = 0; i < n; i++) begin
            bit_i     = i[0];
            bit_valid = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] w, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            bit_i     = w[i];
            bit_valid = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_bits(w, 0, 31);
    endtask

    task automatic pop_one();
        wif.word_ready = 1'b1;
        tick();
        wif.word_ready = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        vecs[0] = '{32'h1234_5678, 32'h1234_5678, 3'd1};
        vecs[1] = '{32'hFFFF_0000, 32'h1234_5678, 3'd2};
        vecs[2] = '{32'h0F0F_0F0F, 32'h1234_5678, 3'd3};
        words   = '{32'h0101_0101, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h8001_0000, 32'h5555_AAAA};

        rst = 1'b1; bit_i = 1'b0; bit_valid = 1'b0; flush = 1'b0; wif.word_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_word_o", wif.word_o, 32'h0);
        check("rst_valid", 32'(wif.word_valid), 32'd0);
        check("rst_fill", 32'(fill_level), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_health", 32'(health_fail), 32'd0);

        // Warm-up then the first word; visible the cycle after its last strobe.
        warmup(64);
        check("warmup_valid", 32'(wif.word_valid), 32'd0);
        send_bits(32'hA5A5_A5A5, 0, 30);
        check("w1_fill_early", 32'(fill_level), 32'd0);
        send_bits(32'hA5A5_A5A5, 31, 31);
        check("w1_word", wif.word_o, 32'hA5A5_A5A5);
        check("w1_valid", 32'(wif.word_valid), 32'd1);
        check("w1_fill", 32'(fill_level), 32'd1);
        pop_one();
        check("w1_pop_fill", 32'(fill_level), 32'd0);

        wif.word_ready = 1'b1;
        tick(); tick();
        wif.word_ready = 1'b0;
        check("empty_pop_fill", 32'(fill_level), 32'd0);

        for (int i = 0; i < 3; i++) begin
            send_word(vecs[i].stim);
            check("tbl_head", wif.word_o, vecs[i].exp_head);
            check("tbl_fill", 32'(fill_level), 32'(vecs[i].exp_fill));
        end
        for (int i = 0; i < 3; i++) begin
            check("tbl_drain", wif.word_o, vecs[i].stim);
            pop_one();
        end
        check("tbl_empty", 32'(fill_level), 32'd0);

        // Overflow on the fifth word, then in-order drain of the first four.
        for (int i = 0; i < 5; i++) begin
            send_word(words[i]);
            if (i == 3) begin
                check("ovf_fill4", 32'(fill_level), 32'd4);
                check("ovf_before", 32'(overflow), 32'd0);
            end
        end
        check("ovf_fill", 32'(fill_level), 32'd4);
        check("ovf_flag", 32'(overflow), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("ovf_drain", wif.word_o, words[i]);
            pop_one();
        end
        check("ovf_drain_fill", 32'(fill_level), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);

        do_flush();
        check("flush_ovf", 32'(overflow), 32'd0);
        check("flush_valid", 32'(wif.word_valid), 32'd0);

        // Full FIFO with a pop in the same cycle as the fifth word's last bit.
        warmup(64);
        for (int i = 0; i < 4; i++) send_word(words[i]);
        check("full_fill", 32'(fill_level), 32'd4);
        send_bits(words[4], 0, 30);
        wif.word_ready = 1'b1;
        send_bits(words[4], 31, 31);
        wif.word_ready = 1'b0;
        check("pp_fill", 32'(fill_level), 32'd4);
        check("pp_overflow", 32'(overflow), 32'd0);
        for (int i = 1; i < 5; i++) begin
            check("pp_drain", wif.word_o, words[i]);
            pop_one();
        end
        check("pp_empty", 32'(fill_level), 32'd0);

        // Flush mid-word with two queued words; warm-up restarts.
        send_word(words[0]);
        send_word(words[1]);
        send_bits(32'h0000_03FF, 0, 9);
        check("f4_fill_pre", 32'(fill_level), 32'd2);
        do_flush();
        check("f4_fill", 32'(fill_level), 32'd0);
        check("f4_ovf", 32'(overflow), 32'd0);
        warmup(64);
        send_bits(32'h3C3C_1234, 0, 30);
        check("f4_fill_95", 32'(fill_level), 32'd0);
        send_bits(32'h3C3C_1234, 31, 31);
        check("f4_fill_96", 32'(fill_level), 32'd1);
        check("f4_word", wif.word_o, 32'h3C3C_1234);
        pop_one();

        // Strobe every third cycle while bit_i toggles every cycle.
        for (int c = 0; c < 94; c++) begin
            bit_i     = c[0];
            bit_valid = (c % 3 == 0);
            tick();
        end
        bit_valid = 1'b0;
        check("sparse_word", wif.word_o, 32'hAAAA_AAAA);
        check("sparse_fill", 32'(fill_level), 32'd1);
        pop_one();

        // 32 consecutive ones in COLLECT.
        do_flush();
        warmup(64);
        send_bits(32'hFFFF_FFFF, 0, 30);
        check("rct_health_pre", 32'(health_fail), 32'd0);
        send_bits(32'hFFFF_FFFF, 31, 31);
`ifdef NLFSR_PACK_RCT_EN
        check("rct_health", 32'(health_fail), 32'd1);
        check("rct_fill", 32'(fill_level), 32'd0);
        send_word(32'h1234_5678);
        check("rct_no_push", 32'(fill_level), 32'd0);
        check("rct_sticky", 32'(health_fail), 32'd1);
        do_flush();
        check("rct_flush", 32'(health_fail), 32'd0);
`else
        check("ones_word", wif.word_o, 32'hFFFF_FFFF);
        check("ones_fill", 32'(fill_level), 32'd1);
        check("ones_health", 32'(health_fail), 32'd0);
`endif

        // Reset mid-word returns every output to its reset value.
        send_bits(32'h0000_0155, 0, 9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_word_o", wif.word_o, 32'h0);
        check("rst2_fill", 32'(fill_level), 32'd0);
        check("rst2_health", 32'(health_fail), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
